// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle control sequencer:
// opcodes, FSM states, mux encodings and opcode classes.
package ctrl_pkg;

    localparam int unsigned OP_AND  = 0;
    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_SUB  = 2;
    localparam int unsigned OP_ADDI = 3;
    localparam int unsigned OP_ANDI = 4;
    localparam int unsigned OP_LW   = 5;
    localparam int unsigned OP_LBU  = 6;
    localparam int unsigned OP_LBS  = 7;
    localparam int unsigned OP_SW   = 8;
    localparam int unsigned OP_SV   = 9;
    localparam int unsigned OP_BEQ  = 10;
    localparam int unsigned OP_BNE  = 11;
    localparam int unsigned OP_BLT  = 12;
    localparam int unsigned OP_BGT  = 13;
    localparam int unsigned OP_JMP  = 14;
    localparam int unsigned OP_CALL = 15;
    localparam int unsigned OP_RET  = 16;
    localparam int unsigned OPC_NUM = 17;

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        PC_INC = 2'd0,
        PC_REL = 2'd1,
        PC_ABS = 2'd2,
        PC_R7  = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        ALU_AND = 2'd0,
        ALU_ADD = 2'd1,
        ALU_SUB = 2'd2
    } alu_op_e;

    typedef struct packed {
        logic alu;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic bad;
    } opc_class_t;

    typedef struct packed {
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       en_if;
        logic       en_id;
        logic       en_ex;
        logic       en_mem;
        logic       en_wb;
        logic       alu_src;
        logic       ext_sel;
        logic       dst_sel;
        logic       wb_sel;
        logic       reg_we;
        logic       r7_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       illegal;
        logic       bus_err;
        logic       busy;
    } ctrl_out_t;

    function automatic opc_class_t classify(input int unsigned opc);
        opc_class_t c;
        c.alu    = opc <= OP_ANDI;
        c.load   = opc >= OP_LW && opc <= OP_LBS;
        c.store  = opc == OP_SW || opc == OP_SV;
        c.branch = opc >= OP_BEQ && opc <= OP_BGT;
        c.jump   = opc >= OP_JMP && opc <= OP_RET;
        c.bad    = opc >= OPC_NUM;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Saturating 8-bit wait counter for the memory handshakes.
// last flags the final non-ready cycle allowed before timeout.
module ctrl_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic count,
    output logic last
);

    logic [7:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count && cnt != 8'hff) begin
            cnt <= cnt + 8'd1;
        end
    end

    // one more idle cycle would make the count reach LIMIT
    assign last = (32'(cnt) + 32'd1) >= LIMIT;

endmodule

// File: rtl/multicycle_ctrl_seq.sv
// Multi-cycle control sequencer with memory timeouts and traps.
// Define CTRL_PERF_EN to add retired/stall performance counters.
module multicycle_ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int unsigned OPC_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero_flag,
    input  logic             neg_flag,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             en_if,
    output logic             en_id,
    output logic             en_ex,
    output logic             en_mem,
    output logic             en_wb,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             ext_sel,
    output logic             dst_sel,
    output logic             wb_sel,
    output logic             reg_we,
    output logic             r7_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             illegal,
    output logic             bus_err,
    output logic             busy
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]      retired_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    state_e      state;
    state_e      nxt;
    ctrl_out_t   q;
    ctrl_out_t   d;
    opc_class_t  cls;
    int unsigned opc;
    logic        waiting;
    logic        ready;
    logic        stall;
    logic        last;
    logic        timeout;
    logic        enter_wait;
    logic        taken;

    assign opc        = 32'(opcode);
    assign cls        = classify(opc);
    assign waiting    = state == S_FETCH || state == S_MEM;
    assign ready      = state == S_FETCH ? imem_ready : dmem_ready;
    assign stall      = waiting && !ready;
    assign timeout    = stall && last;
    assign enter_wait = (nxt == S_FETCH || nxt == S_MEM) && nxt != state;

    ctrl_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (enter_wait),
        .count   (stall),
        .last    (last)
    );

    always_comb begin
        taken = 1'b0;
        unique case (opc)
            OP_BEQ:  taken = zero_flag;
            OP_BNE:  taken = !zero_flag;
            OP_BLT:  taken = neg_flag;
            OP_BGT:  taken = !neg_flag && !zero_flag;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
            q     <= '0;
        end else begin
            state <= nxt;
            q     <= d;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_INIT: nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ready)   nxt = S_DECODE;
                else if (timeout) nxt = S_HALT;
            end
            S_DECODE: begin
                if (cls.bad)       nxt = S_HALT;
                else if (cls.jump) nxt = S_FETCH;
                else               nxt = S_EXEC;
            end
            S_EXEC: begin
                if (cls.load || cls.store) nxt = S_MEM;
                else if (cls.branch)       nxt = S_FETCH;
                else if (cls.alu)          nxt = S_WB;
                else                       nxt = S_HALT;
            end
            S_MEM: begin
                if (dmem_ready)   nxt = cls.load ? S_WB : S_FETCH;
                else if (timeout) nxt = S_HALT;
            end
            S_WB:    nxt = S_FETCH;
            S_HALT:  nxt = S_HALT;
            default: nxt = S_HALT;
        endcase
    end

    // outputs are computed for the state being entered, then registered
    always_comb begin
        d         = '0;
        d.pc_src  = q.pc_src;
        d.ext_sel = q.ext_sel;
        d.dst_sel = q.dst_sel;
        d.illegal = q.illegal;
        d.bus_err = q.bus_err | timeout;
        d.busy    = nxt != S_HALT;
        d.en_if   = nxt == S_FETCH;
        d.en_id   = nxt == S_DECODE;
        d.en_ex   = nxt == S_EXEC;
        d.en_mem  = nxt == S_MEM;
        d.en_wb   = nxt == S_WB;
        unique case (state)
            S_FETCH: begin
                if (imem_ready) begin
                    d.pc_src  = PC_INC;
                    d.ext_sel = 1'b0;
                    d.dst_sel = 1'b0;
                end
            end
            S_DECODE: begin
                d.ext_sel = cls.branch || opc == OP_LBU
                         || opc == OP_LBS;
                d.dst_sel = opc == OP_CALL;
                d.r7_we   = opc == OP_CALL;
                d.illegal = q.illegal | cls.bad;
                if (cls.jump) begin
                    d.pc_src = opc == OP_RET ? PC_R7 : PC_ABS;
                end
            end
            S_EXEC: begin
                if (cls.branch && taken) d.pc_src = PC_REL;
            end
            default: ;
        endcase
        if (nxt == S_EXEC) begin
            d.alu_src = opc == OP_ADDI || opc == OP_ANDI
                     || cls.load || opc == OP_SW;
            unique case (1'b1)
                opc == OP_AND || opc == OP_ANDI:
                    d.alu_op = ALU_AND;
                opc == OP_ADD || opc == OP_ADDI
                || cls.load || cls.store:
                    d.alu_op = ALU_ADD;
                default:
                    d.alu_op = ALU_SUB;
            endcase
        end
        d.mem_rd = nxt == S_MEM && cls.load;
        d.mem_wr = nxt == S_MEM && cls.store;
        d.reg_we = nxt == S_WB;
        d.wb_sel = nxt == S_WB && cls.load;
        if (nxt == S_HALT) begin
            d.pc_src  = PC_INC;
            d.ext_sel = 1'b0;
            d.dst_sel = 1'b0;
            d.r7_we   = 1'b0;
        end
    end

    assign en_if   = q.en_if;
    assign en_id   = q.en_id;
    assign en_ex   = q.en_ex;
    assign en_mem  = q.en_mem;
    assign en_wb   = q.en_wb;
    assign pc_src  = q.pc_src;
    assign alu_op  = q.alu_op;
    assign alu_src = q.alu_src;
    assign ext_sel = q.ext_sel;
    assign dst_sel = q.dst_sel;
    assign wb_sel  = q.wb_sel;
    assign reg_we  = q.reg_we;
    assign r7_we   = q.r7_we;
    assign mem_rd  = q.mem_rd;
    assign mem_wr  = q.mem_wr;
    assign illegal = q.illegal;
    assign bus_err = q.bus_err;
    assign busy    = q.busy;

`ifdef CTRL_PERF_EN
    logic retire;

    assign retire = nxt == S_FETCH
                 && (state == S_DECODE || state == S_EXEC
                  || state == S_MEM || state == S_WB);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (retire) retired_cnt <= retired_cnt + 32'd1;
            if (stall)  stall_cnt   <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Bench for multicycle_ctrl_seq: per-instruction trace model
// expanded into expected per-cycle outputs and compared each cycle.
module tb_multicycle_ctrl_seq;

    localparam int T = 15;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] opcode = '0;
    logic       zero_flag = 1'b0;
    logic       neg_flag = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       en_if, en_id, en_ex, en_mem, en_wb;
    logic [1:0] pc_src, alu_op;
    logic       alu_src, ext_sel, dst_sel, wb_sel;
    logic       reg_we, r7_we, mem_rd, mem_wr;
    logic       illegal, bus_err, busy;
`ifdef CTRL_PERF_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    multicycle_ctrl_seq #(
        .OPC_W       (5),
        .MEM_TIMEOUT (T)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .zero_flag  (zero_flag),
        .neg_flag   (neg_flag),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .en_if      (en_if),
        .en_id      (en_id),
        .en_ex      (en_ex),
        .en_mem     (en_mem),
        .en_wb      (en_wb),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .ext_sel    (ext_sel),
        .dst_sel    (dst_sel),
        .wb_sel     (wb_sel),
        .reg_we     (reg_we),
        .r7_we      (r7_we),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .busy       (busy)
`ifdef CTRL_PERF_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic en_if, en_id, en_ex, en_mem, en_wb;
        logic alu_src, ext_sel, dst_sel, wb_sel;
        logic reg_we, r7_we, mem_rd, mem_wr;
        logic illegal, bus_err, busy;
    } obs_t;

    typedef struct packed {
        logic [4:0] opc;
        logic zf, nf, ir, dr;
    } stim_t;

    obs_t  exp_q[$];
    stim_t stim_q[$];
    int    errors = 0;
    int    checks = 0;
    int    n_mem_rd = 0;
    int    n_reg_we = 0;
    int    n_r7_we = 0;

    logic [1:0] pend_pc;
    bit pend_ext, pend_dst, pend_r7;
    bit m_ill, m_berr, m_halt;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic obs_t actual();
        obs_t o;
        o.pc_src = pc_src;   o.alu_op = alu_op;
        o.en_if = en_if;     o.en_id = en_id;
        o.en_ex = en_ex;     o.en_mem = en_mem;
        o.en_wb = en_wb;     o.alu_src = alu_src;
        o.ext_sel = ext_sel; o.dst_sel = dst_sel;
        o.wb_sel = wb_sel;   o.reg_we = reg_we;
        o.r7_we = r7_we;     o.mem_rd = mem_rd;
        o.mem_wr = mem_wr;   o.illegal = illegal;
        o.bus_err = bus_err; o.busy = busy;
        return o;
    endfunction

    task automatic drive(input stim_t s);
        opcode = s.opc;
        zero_flag = s.zf;
        neg_flag = s.nf;
        imem_ready = s.ir;
        dmem_ready = s.dr;
    endtask

    task automatic m_reset();
        exp_q.delete();
        stim_q.delete();
        pend_pc = 2'd0;
        pend_ext = 0; pend_dst = 0; pend_r7 = 0;
        m_ill = 0; m_berr = 0; m_halt = 0;
    endtask

    function automatic obs_t base();
        obs_t o = '0;
        o.illegal = m_ill;
        o.bus_err = m_berr;
        o.busy = 1'b1;
        return o;
    endfunction

    task automatic push(input obs_t o, input stim_t s);
        exp_q.push_back(o);
        stim_q.push_back(s);
    endtask

    task automatic halt(input stim_t s);
        obs_t o;
        for (int j = 0; j < 3; j++) begin
            o = '0;
            o.illegal = m_ill;
            o.bus_err = m_berr;
            push(o, s);
        end
        m_halt = 1;
    endtask

    function automatic bit br_taken(input int opc, input bit zf,
                                    input bit nf);
        case (opc)
            10: return zf;
            11: return !zf;
            12: return nf;
            default: return !nf && !zf;
        endcase
    endfunction

    // One instruction: iw/dw are non-ready cycles before ready.
    task automatic add(input int opc, input bit zf, input bit nf,
                       input int iw, input int dw);
        obs_t o;
        stim_t s;
        bit ld, st, br, ext;
        int n;
        if (m_halt) return;
        s = '0;
        s.opc = opc[4:0];
        ld = opc >= 5 && opc <= 7;
        st = opc == 8 || opc == 9;
        br = opc >= 10 && opc <= 13;
        n = (iw >= T) ? T : iw + 1;
        for (int j = 0; j < n; j++) begin
            o = base();
            o.en_if = 1;
            o.pc_src = pend_pc;
            o.ext_sel = pend_ext;
            o.dst_sel = pend_dst;
            o.r7_we = pend_r7 && j == 0;
            s.ir = (j == iw);
            push(o, s);
        end
        s.ir = 0;
        if (iw >= T) begin
            m_berr = 1;
            halt(s);
            return;
        end
        pend_pc = 2'd0;
        pend_ext = 0; pend_dst = 0; pend_r7 = 0;
        o = base();
        o.en_id = 1;
        push(o, s);
        if (opc >= 17) begin
            m_ill = 1;
            halt(s);
            return;
        end
        ext = br || opc == 6 || opc == 7;
        if (opc >= 14) begin
            pend_pc = (opc == 16) ? 2'd3 : 2'd2;
            pend_dst = opc == 15;
            pend_r7 = opc == 15;
            return;
        end
        o = base();
        o.en_ex = 1;
        o.ext_sel = ext;
        o.alu_src = opc >= 3 && opc <= 8;
        if (opc == 0 || opc == 4) o.alu_op = 2'd0;
        else if (opc == 1 || opc == 3 || ld || st) o.alu_op = 2'd1;
        else o.alu_op = 2'd2;
        s.zf = zf;
        s.nf = nf;
        push(o, s);
        s.zf = 0;
        s.nf = 0;
        if (br) begin
            pend_pc = br_taken(opc, zf, nf) ? 2'd1 : 2'd0;
            pend_ext = ext;
            return;
        end
        if (ld || st) begin
            n = (dw >= T) ? T : dw + 1;
            for (int j = 0; j < n; j++) begin
                o = base();
                o.en_mem = 1;
                o.ext_sel = ext;
                o.mem_rd = ld;
                o.mem_wr = st;
                s.dr = (j == dw);
                push(o, s);
            end
            s.dr = 0;
            if (dw >= T) begin
                m_berr = 1;
                halt(s);
                return;
            end
            if (st) begin
                pend_ext = ext;
                return;
            end
        end
        o = base();
        o.en_wb = 1;
        o.reg_we = 1;
        o.wb_sel = ld;
        o.ext_sel = ext;
        push(o, s);
        pend_ext = ext;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 0;
        drive('0);
        #2;
        check("reset_outputs", {12'd0, actual()}, 32'd0);
        @(negedge clock);
        reset_n = 1;
        m_reset();
    endtask

    task automatic run(input string tag, input int upto);
        for (int k = 0; k < upto; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s_cyc%0d", tag, k),
                  {12'd0, actual()}, {12'd0, exp_q[k]});
            n_mem_rd += int'(mem_rd);
            n_reg_we += int'(reg_we);
            n_r7_we += int'(r7_we);
            drive(stim_q[k]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int i0, i1;
        m_reset();
        repeat (2) @(posedge clock);

        // program 1: mixed instruction stream ending in a trap
        do_reset();
        i0 = exp_q.size();
        add(1, 0, 0, 0, 0);
        check("model_add_len", exp_q.size() - i0, 4);
        i0 = exp_q.size();
        add(5, 0, 0, 0, 3);
        check("model_lw_len", exp_q.size() - i0, 8);
        i0 = exp_q.size();
        add(10, 1, 0, 0, 0);
        check("model_beq_len", exp_q.size() - i0, 3);
        i0 = exp_q.size();
        add(10, 0, 0, 0, 0);
        check("model_beq_taken_pc", exp_q[i0].pc_src, 1);
        i1 = exp_q.size();
        add(13, 0, 0, 1, 0);
        check("model_beq_fall_pc", exp_q[i1].pc_src, 0);
        add(12, 0, 0, 0, 0);
        i0 = exp_q.size();
        add(15, 0, 0, 0, 0);
        check("model_call_len", exp_q.size() - i0, 2);
        i1 = exp_q.size();
        add(16, 0, 0, 2, 0);
        check("model_call_pc", exp_q[i1].pc_src, 2);
        check("model_call_r7", exp_q[i1].r7_we, 1);
        i1 = exp_q.size();
        add(14, 0, 0, 0, 0);
        check("model_ret_pc", exp_q[i1].pc_src, 3);
        i0 = exp_q.size();
        add(8, 0, 0, 0, 0);
        check("model_sw_len", exp_q.size() - i0, 4);
        add(2, 0, 0, 0, 0);
        add(4, 0, 0, 0, 0);
        add(9, 0, 0, 0, 1);
        add(7, 0, 0, 0, 0);
        add(20, 0, 0, 0, 0);
        run("p1", exp_q.size());
        check("p1_mem_rd_cycles", n_mem_rd, 5);
        check("p1_reg_we_cycles", n_reg_we, 5);
        check("p1_r7_we_pulses", n_r7_we, 1);
        check("p1_illegal", illegal, 1);
        check("p1_busy", busy, 0);

        // program 2: ready on the last allowed cycle, then a timeout
        do_reset();
        add(8, 0, 0, 0, T - 1);
        i0 = exp_q.size();
        add(8, 0, 0, 0, 99);
        check("model_sw_timeout_len", exp_q.size() - i0, 21);
        run("p2", exp_q.size());
        check("p2_bus_err", bus_err, 1);
        check("p2_mem_wr", mem_wr, 0);
        check("p2_busy", busy, 0);

        // program 3: instruction fetch never completes
        do_reset();
        add(1, 0, 0, 99, 0);
        run("p3", exp_q.size());
        check("p3_bus_err", bus_err, 1);
        check("p3_illegal", illegal, 0);

        // program 4: reset asserted while a store waits in MEM
        do_reset();
        add(8, 0, 0, 0, 99);
        run("p4", 5);
        check("p4_mem_wr_before", mem_wr, 1);
        #3;
        reset_n = 0;
        #1;
        check("p4_async_mem_wr", mem_wr, 0);
        check("p4_async_all", {12'd0, actual()}, 32'd0);
        drive('0);
        @(negedge clock);
        reset_n = 1;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("p4_resume_en_if", en_if, 1);
        check("p4_resume_busy", busy, 1);
        check("p4_resume_mem_wr", mem_wr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
